diffeq_rr_scheduler: RTL and testbench

//  Time-multiplexes one first-order recursion datapath y[n] = x[n] + a*y[n-1]

---
 rtl/diffeq_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/diffeq_rr_scheduler.sv | 92 +++++++++
 tb/tb_diffeq_rr_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/diffeq_pkg.sv
// Shared types and arithmetic for time-multiplexed recursion blocks.
// Provides the FSM state type, a width helper and one recursion step y = x + a*y1.
package diffeq_pkg;

  typedef enum logic [1:0] {IDLE, CALC, OUT} fsm_state_t;

  // Never returns less than 1 so that single-bit index fields stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Operands ride in 32-bit containers; w/cw must be constants at the call site.
  function automatic logic [31:0] diffeq_step(input logic [31:0] x, input logic [31:0] y1,
                                              input logic [31:0] a, input int w, input int cw,
                                              input logic sat);
    logic [63:0] prod;
    logic [63:0] sum;
    logic [63:0] lim;
    prod = ({32'd0, y1} * {32'd0, a}) >> cw;
    sum  = {32'd0, x} + prod;
    lim  = (64'd1 << w) - 64'd1;
    if (sat && (sum > lim)) return lim[31:0];
    return sum[31:0] & lim[31:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping mod NCH.
// Purely combinational; grant is one-hot or zero.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] grant,
  output logic [CHW-1:0] grant_idx,
  output logic           any_grant
);

  logic [CHW-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = CHW'((int'(ptr) + k) % NCH);
      if (req[cand]) begin
        grant_idx = cand;
        any_grant = 1'b1;
      end
    end
    if (any_grant) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/diffeq_rr_scheduler.sv
// Shares one y = x + a*y[n-1] datapath across NCH channels with round-robin arbitration.
// Accept at t gives out_valid from t+2; result holds until out_ready, then the next grant.
module diffeq_rr_scheduler
  import diffeq_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int CW  = 8,
  parameter int SAT = 0,
  localparam int CHW = clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH*W-1:0] req_data,
  output logic [NCH-1:0]   req_ready,
  input  logic [NCH-1:0]   clr,
  input  logic [CW-1:0]    coef,
  output logic             out_valid,
  output logic [CHW-1:0]   out_ch,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic             busy
);

  fsm_state_t     fsm_q;
  logic [CHW-1:0] ptr_q;
  logic [CHW-1:0] g_q;
  logic [W-1:0]   x_q;
  logic [CW-1:0]  a_q;
  logic [W-1:0]   state_q [NCH];

  logic [NCH-1:0] grant;
  logic [CHW-1:0] grant_idx;
  logic           any_grant;
  logic [W-1:0]   y;

  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = (fsm_q == IDLE) ? grant : '0;
  assign busy      = (fsm_q != IDLE);
  assign y         = W'(diffeq_step(32'(x_q), 32'(state_q[g_q]), 32'(a_q), W, CW, SAT != 0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q     <= IDLE;
      ptr_q     <= '0;
      g_q       <= '0;
      x_q       <= '0;
      a_q       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      for (int i = 0; i < NCH; i++) state_q[i] <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (any_grant) begin
            g_q   <= grant_idx;
            x_q   <= req_data[grant_idx*W +: W];
            a_q   <= coef;
            fsm_q <= CALC;
          end
        end
        CALC: begin
          out_data       <= y;
          out_ch         <= g_q;
          out_valid      <= 1'b1;
          state_q[g_q]   <= y;
          fsm_q          <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr_q     <= (g_q == CHW'(NCH - 1)) ? '0 : g_q + CHW'(1);
            fsm_q     <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
      // Issued last so a clear beats the CALC write-back to the same entry.
      for (int i = 0; i < NCH; i++) if (clr[i]) state_q[i] <= '0;
    end
  end

endmodule

// File: tb/tb_diffeq_rr_scheduler.sv
// Random and directed stimulus for wrap and saturating instances side by side,
// scored against a transaction-level model of the recursion and round-robin order.
module tb_diffeq_rr_scheduler;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int CW  = 8;
  localparam int CHW = 2;

  logic             clk;
  logic             reset;
  logic [NCH-1:0]   rv;
  logic [NCH*W-1:0] rd;
  logic [NCH-1:0]   clr;
  logic [CW-1:0]    coef_s;
  logic             ordy;
  logic [NCH-1:0]   rr0, rr1;
  logic             ov0, ov1, busy0, busy1;
  logic [CHW-1:0]   och0, och1;
  logic [W-1:0]     od0, od1;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int st0[NCH];
  int st1[NCH];
  int mptr, acc_cyc, exp_ch, y0, y1, cyc;
  bit mb;
  logic [NCH-1:0] acc_mask;
  int got0[$];
  int got1[$];
  int gotch[$];

  // stimulus knobs
  logic [NCH-1:0] en;
  int fix_x, fix_coef, p_req, p_ordy, p_clr;
  bit clr_calc;

  diffeq_rr_scheduler #(.NCH(NCH), .W(W), .CW(CW), .SAT(0)) dut_wrap (
    .clk(clk), .reset(reset), .req_valid(rv), .req_data(rd), .req_ready(rr0), .clr(clr),
    .coef(coef_s), .out_valid(ov0), .out_ch(och0), .out_data(od0), .out_ready(ordy), .busy(busy0)
  );

  diffeq_rr_scheduler #(.NCH(NCH), .W(W), .CW(CW), .SAT(1)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(rv), .req_data(rd), .req_ready(rr1), .clr(clr),
    .coef(coef_s), .out_valid(ov1), .out_ch(och1), .out_data(od1), .out_ready(ordy), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ref_step(input int x, input int yprev, input int a, input bit sat);
    int s;
    s = x + (yprev * a) / (1 << CW);
    if (sat) return (s > (1 << W) - 1) ? (1 << W) - 1 : s;
    return s % (1 << W);
  endfunction

  task automatic drive();
    rv  = rv & ~acc_mask;
    clr = clr_calc ? acc_mask : '0;
    acc_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!rv[i] && en[i] && ($urandom_range(99) < p_req)) begin
        rv[i] = 1'b1;
        rd[i*W +: W] = (fix_x >= 0) ? W'(fix_x) : W'($urandom);
      end
      if ((p_clr > 0) && ($urandom_range(99) < p_clr)) clr[i] = 1'b1;
    end
    coef_s = (fix_coef >= 0) ? CW'(fix_coef) : CW'($urandom);
    ordy   = ($urandom_range(99) < p_ordy);
  endtask

  task automatic evaluate();
    logic [NCH-1:0] exp_rdy;
    int g, idx, b0, b1;
    exp_rdy = '0;
    g = -1;
    if (!mb) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (mptr + k) % NCH;
        if (g < 0 && rv[idx]) g = idx;
      end
      chk("busy_idle", busy0, 0);
      chk("ov_idle", ov0, 0);
      chk("ov_idle_sat", ov1, 0);
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        b0 = clr[g] ? 0 : st0[g];
        b1 = clr[g] ? 0 : st1[g];
        y0 = ref_step(int'(rd[g*W +: W]), b0, int'(coef_s), 1'b0);
        y1 = ref_step(int'(rd[g*W +: W]), b1, int'(coef_s), 1'b1);
        mb = 1'b1;
        acc_cyc = cyc;
        exp_ch = g;
        acc_mask[g] = 1'b1;
      end
    end else begin
      chk("busy", busy0, 1);
      chk("busy_sat", busy1, 1);
      if (cyc == acc_cyc + 1) begin
        chk("ov_latency", ov0, 0);
      end else begin
        chk("ov", ov0, 1);
        chk("ov_sat", ov1, 1);
        chk("out_ch", och0, exp_ch);
        chk("out_ch_sat", och1, exp_ch);
        chk("out_data", od0, y0);
        chk("out_data_sat", od1, y1);
        if (ordy) begin
          mb = 1'b0;
          mptr = (exp_ch + 1) % NCH;
          got0.push_back(int'(od0));
          got1.push_back(int'(od1));
          gotch.push_back(int'(och0));
        end
      end
    end
    chk("req_ready", rr0, exp_rdy);
    chk("req_ready_sat", rr1, exp_rdy);
    for (int i = 0; i < NCH; i++) if (clr[i]) begin st0[i] = 0; st1[i] = 0; end
    if (g >= 0) begin st0[g] = y0; st1[g] = y1; end
  endtask

  task automatic cycle();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin drive(); cycle(); end
  endtask

  task automatic run_outs(input string tag, input int n, input int budget);
    got0.delete(); got1.delete(); gotch.delete();
    for (int c = 0; c < budget && got0.size() < n; c++) begin drive(); cycle(); end
    chk(tag, got0.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rv = '0; clr = '0; ordy = 1'b0; acc_mask = '0;
    @(negedge clk);
    chk("rst_ov", ov0, 0);
    chk("rst_ov_sat", ov1, 0);
    chk("rst_out_ch", och0, 0);
    chk("rst_out_data", od0, 0);
    chk("rst_out_data_sat", od1, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_req_ready", rr0, 0);
    mb = 1'b0; mptr = 0;
    for (int i = 0; i < NCH; i++) begin st0[i] = 0; st1[i] = 0; end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_mode(input logic [NCH-1:0] e, input int fx, input int fc, input int pr, input int po, input int pc);
    en = e; fix_x = fx; fix_coef = fc; p_req = pr; p_ordy = po; p_clr = pc; clr_calc = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rv = '0; rd = '0; clr = '0; coef_s = '0; ordy = 1'b0;
    cyc = 0; mb = 1'b0; mptr = 0; acc_cyc = 0; exp_ch = 0; y0 = 0; y1 = 0; acc_mask = '0;
    set_mode('0, -1, -1, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // single channel, a = 0 then a = 0.5
    do_reset();
    set_mode(4'b0001, 10, 0, 100, 100, 0);
    run_outs("single_a0_cnt", 3, 30);
    if (got0.size() >= 3) for (int k = 0; k < 3; k++) chk("single_a0", got0[k], 10);
    do_reset();
    set_mode(4'b0001, 10, 128, 100, 100, 0);
    run_outs("single_a05_cnt", 4, 40);
    if (got0.size() >= 4) begin
      chk("single_a05_0", got0[0], 10);
      chk("single_a05_1", got0[1], 15);
      chk("single_a05_2", got0[2], 17);
      chk("single_a05_3", got0[3], 18);
    end

    // overflow on ch1: wrap vs saturate
    do_reset();
    set_mode(4'b0010, 200, 255, 100, 100, 0);
    run_outs("ovf_cnt", 3, 30);
    if (got0.size() >= 3) begin
      chk("wrap_0", got0[0], 200);
      chk("wrap_1", got0[1], 143);
      chk("wrap_2", got0[2], 86);
      chk("sat_0", got1[0], 200);
      chk("sat_1", got1[1], 255);
      chk("sat_2", got1[2], 255);
    end

    // clear colliding with the CALC write-back of ch2
    set_mode(4'b0100, 200, 128, 100, 100, 0);
    run_outs("clr_pre_cnt", 2, 30);
    set_mode(4'b0100, 7, 128, 100, 100, 0);
    clr_calc = 1'b1;
    run_outs("clr_cnt", 4, 40);
    if (got0.size() >= 4) begin
      chk("clr_y_a", got0[2], 7);
      chk("clr_y_b", got0[3], 7);
    end
    clr_calc = 1'b0;

    // random traffic with clears, backpressure and changing coef
    set_mode('1, -1, -1, 50, 70, 5);
    run_cycles(1500);

    // reset while a result is waiting in OUT
    set_mode('1, -1, -1, 100, 0, 0);
    for (int c = 0; c < 20 && !(mb && cyc >= acc_cyc + 2); c++) begin drive(); cycle(); end
    chk("pre_rst_ov", ov0, 1);
    do_reset();

    // round-robin order from pointer 0 with all channels requesting
    set_mode('1, -1, -1, 100, 100, 0);
    run_outs("rr_cnt", 6, 40);
    if (gotch.size() >= 6) for (int k = 0; k < 6; k++) chk("rr_order", gotch[k], k % NCH);

    // downstream stall
    set_mode('1, -1, -1, 100, 0, 0);
    run_cycles(8);
    set_mode('1, -1, -1, 100, 100, 0);
    run_outs("bp_cnt", 2, 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
